// File: rtl/VX_gpu_pkg.sv
// Shared GPU types for the issue slice: ibuffer payload and the issue-arbiter entry.
package VX_gpu_pkg;

  localparam int unsigned ISSUE_NUM_WARPS = 4;
  localparam int unsigned ISSUE_WID_W     = $clog2(ISSUE_NUM_WARPS);

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  op_type;
    logic [4:0]  rd;
    logic        wb;
  } ibuffer_t;

  localparam int unsigned IBUF_DATAW = $bits(ibuffer_t);

  typedef struct packed {
    ibuffer_t                 data;
    logic [ISSUE_WID_W-1:0]   wid;
  } issue_arb_entry_t;

endpackage

// File: rtl/vx_rr_pick.sv
// Round-robin priority picker: first requester at or above ptr, wrapping to 0.
module vx_rr_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] scan_idx;

  // N is a power of two, so the wrap is the natural IW-bit overflow.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    scan_idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      scan_idx = ptr + IW'(i);
      if (!grant_valid && req[scan_idx]) begin
        grant_valid     = 1'b1;
        grant_idx       = scan_idx;
        grant[scan_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_ibuffer_issue_arb.sv
// Per-warp ibuffer consumer: round-robin pick of a non-stalled warp into a
// 2-entry elastic buffer feeding dispatch.
module vx_ibuffer_issue_arb
  import VX_gpu_pkg::*;
#(
  parameter  int unsigned NUM_WARPS = 4,
  localparam int unsigned WID_W     = $clog2(NUM_WARPS),
  localparam int unsigned DATAW     = IBUF_DATAW
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_WARPS-1:0]            ibuf_valid,
  input  logic [NUM_WARPS-1:0][DATAW-1:0] ibuf_data,
  output logic [NUM_WARPS-1:0]            ibuf_ready,
  input  logic [NUM_WARPS-1:0]            warp_stall,
  output logic                            issue_valid,
  output logic [DATAW-1:0]                issue_data,
  output logic [WID_W-1:0]                issue_wid,
  input  logic                            issue_ready,
  output logic                            busy
);

  typedef struct packed {
    ibuffer_t          data;
    logic [WID_W-1:0]  wid;
  } entry_t;

  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] grant;
  logic [WID_W-1:0]     grant_idx;
  logic                 grant_valid;

  logic [WID_W-1:0] rr_ptr_q, rr_ptr_d;
  entry_t           buf_q [2];
  entry_t           buf_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  logic has_space;
  logic push;
  logic pop;

  assign eligible = ibuf_valid & ~warp_stall;

  vx_rr_pick #(
    .N (NUM_WARPS)
  ) u_pick (
    .req         (eligible),
    .ptr         (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Space comes from the registered count only, so a pop never frees a slot
  // for a push in the same cycle; reset_n gating keeps ready low during reset.
  assign has_space   = reset_n && (count_q != 2'd2);
  assign ibuf_ready  = has_space ? grant : '0;
  assign push        = has_space && grant_valid;
  assign issue_valid = (count_q != 2'd0);
  assign pop         = issue_valid && issue_ready;
  assign busy        = issue_valid;
  assign issue_data  = buf_q[rd_ptr_q].data;
  assign issue_wid   = buf_q[rd_ptr_q].wid;

  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    if (push) begin
      buf_d[wr_ptr_q] = '{data: ibuffer_t'(ibuf_data[grant_idx]), wid: grant_idx};
      wr_ptr_d        = ~wr_ptr_q;
      rr_ptr_d        = grant_idx + WID_W'(1);
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      buf_q    <= buf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  a_ready_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(ibuf_ready));
  a_no_push_full:  assert property (@(posedge clk) disable iff (!reset_n) !(push && count_q == 2'd2));
  a_no_pop_empty:  assert property (@(posedge clk) disable iff (!reset_n) !(pop && count_q == 2'd0));

endmodule

// File: tb/tb_vx_ibuffer_issue_arb.sv
// Directed bench for vx_ibuffer_issue_arb: reset, fairness, stall skip,
// backpressure, wrap and mid-stream async reset.
module tb_vx_ibuffer_issue_arb;
  import VX_gpu_pkg::*;

  localparam int unsigned NW    = 4;
  localparam int unsigned WW    = $clog2(NW);
  localparam int unsigned DW    = IBUF_DATAW;

  logic                     clk;
  logic                     reset_n;
  logic [NW-1:0]            ibuf_valid;
  logic [NW-1:0][DW-1:0]    ibuf_data;
  logic [NW-1:0]            ibuf_ready;
  logic [NW-1:0]            warp_stall;
  logic                     issue_valid;
  logic [DW-1:0]            issue_data;
  logic [WW-1:0]            issue_wid;
  logic                     issue_ready;
  logic                     busy;

  int checks;
  int failures;
  int gen;

  vx_ibuffer_issue_arb #(
    .NUM_WARPS (NW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ibuf_valid  (ibuf_valid),
    .ibuf_data   (ibuf_data),
    .ibuf_ready  (ibuf_ready),
    .warp_stall  (warp_stall),
    .issue_valid (issue_valid),
    .issue_data  (issue_data),
    .issue_wid   (issue_wid),
    .issue_ready (issue_ready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ibuffer_t data_of(input int w, input int g);
    ibuffer_t d;
    d.pc      = 32'h8000_0000 | (w << 8) | g;
    d.op_type = 4'(w + 3);
    d.rd      = 5'(g);
    d.wb      = w[0];
    return d;
  endfunction

  task automatic apply_data();
    for (int w = 0; w < int'(NW); w++) ibuf_data[w] = data_of(w, gen);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  int exp_seq[4] = '{2, 3, 0, 2};

  initial begin
    checks      = 0;
    failures    = 0;
    gen         = 0;
    reset_n     = 1'b0;
    ibuf_valid  = 4'b1111;
    warp_stall  = 4'b0000;
    issue_ready = 1'b0;
    apply_data();

    // 1: reset holds ready low even with every warp valid
    step(); step(); step();
    check("rst_ready", 64'(ibuf_ready), 64'h0);
    check("rst_valid", 64'(issue_valid), 64'h0);
    check("rst_busy",  64'(busy), 64'h0);

    reset_n     = 1'b1;
    issue_ready = 1'b1;
    #1;
    check("post_rst_grant", 64'(ibuf_ready), 64'b0001);
    step();

    // 2: fairness, one issue per cycle in warp order
    for (int k = 0; k < 6; k++) begin
      check("fair_valid", 64'(issue_valid), 64'h1);
      check("fair_wid",   64'(issue_wid), 64'(k % 4));
      check("fair_data",  64'(issue_data), 64'(data_of(k % 4, 0)));
      if (k == 5) ibuf_valid = 4'b0000;
      step();
    end
    check("fair_drained", 64'(issue_valid), 64'h0);

    // 3: stall skip from rr_ptr=1
    ibuf_valid = 4'b0001;
    #1;
    check("wrap_to_w0", 64'(ibuf_ready), 64'b0001);
    step();
    ibuf_valid = 4'b1111;
    warp_stall = 4'b0010;
    #1;
    check("stall_grant", 64'(ibuf_ready), 64'b0100);
    for (int j = 0; j < 4; j++) begin
      step();
      check("stall_seq", 64'(issue_wid), 64'(exp_seq[j]));
    end
    ibuf_valid = 4'b0000;
    warp_stall = 4'b0000;
    step();
    check("stall_drained_busy", 64'(busy), 64'h0);

    // 4: backpressure fills both entries and holds the head
    issue_ready = 1'b0;
    ibuf_valid  = 4'b1111;
    #1;
    check("bp_first_ready", 64'(ibuf_ready), 64'b1000);
    step();
    check("bp_wid_a",   64'(issue_wid), 64'd3);
    check("bp_ready_a", 64'(ibuf_ready), 64'b0001);
    step();
    check("bp_full_ready", 64'(ibuf_ready), 64'h0);
    check("bp_full_busy",  64'(busy), 64'h1);
    gen = 5;
    apply_data();
    step();
    check("bp_hold_wid",  64'(issue_wid), 64'd3);
    check("bp_hold_data", 64'(issue_data), 64'(data_of(3, 0)));
    check("bp_hold_ready", 64'(ibuf_ready), 64'h0);
    issue_ready = 1'b1;
    #1;
    check("bp_pop_no_push", 64'(ibuf_ready), 64'h0);
    step();
    check("bp_drain_wid",  64'(issue_wid), 64'd0);
    check("bp_drain_data", 64'(issue_data), 64'(data_of(0, 0)));
    check("bp_accept_again", 64'(ibuf_ready), 64'b0010);
    ibuf_valid = 4'b0000;
    step();
    check("bp_empty", 64'(issue_valid), 64'h0);

    // 5: wrap 3 -> 0
    ibuf_valid = 4'b0100;
    step();
    ibuf_valid = 4'b1000;
    #1;
    check("wrap_g3", 64'(ibuf_ready), 64'b1000);
    step();
    check("wrap_wid3",  64'(issue_wid), 64'd3);
    check("wrap_data3", 64'(issue_data), 64'(data_of(3, 5)));
    ibuf_valid = 4'b0001;
    #1;
    check("wrap_g0", 64'(ibuf_ready), 64'b0001);
    step();
    check("wrap_wid0", 64'(issue_wid), 64'd0);
    ibuf_valid = 4'b1111;
    #1;
    check("wrap_ptr1", 64'(ibuf_ready), 64'b0010);

    // 6: async reset with two entries buffered
    issue_ready = 1'b0;
    step();
    check("mid_full_ready", 64'(ibuf_ready), 64'h0);
    check("mid_full_busy",  64'(busy), 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(issue_valid), 64'h0);
    check("mid_rst_busy",  64'(busy), 64'h0);
    check("mid_rst_ready", 64'(ibuf_ready), 64'h0);
    #2;
    warp_stall = 4'b0001;
    reset_n    = 1'b1;
    #1;
    check("mid_post_grant", 64'(ibuf_ready), 64'b0010);
    step();
    check("mid_post_valid", 64'(issue_valid), 64'h1);
    check("mid_post_wid",   64'(issue_wid), 64'd1);
    check("mid_post_data",  64'(issue_data), 64'(data_of(1, 5)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
